// File: rtl/vm_req_arbiter.sv
// Round-robin arbiter that shares one MMU request port among NUM_REQ requesters,
// sequencing each granted request through issue, completion wait and a done pulse.
module vm_req_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 1023
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ-1:0]          req_write,
   input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
   input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
   output logic [NUM_REQ-1:0]          req_done,
   output logic                        req_err,
   output logic [DATA_W-1:0]           req_rdata,
   output logic [$clog2(NUM_REQ)-1:0]  grant_id,
   output logic                        busy,
   output logic                        mmu_valid,
   output logic                        mmu_write,
   output logic [ADDR_W-1:0]           mmu_addr,
   output logic [DATA_W-1:0]           mmu_wdata,
   input  logic                        mmu_ready,
   input  logic                        mem_ready,
   input  logic [DATA_W-1:0]           mem_rdata,
   output logic [1:0]                  dbg_state
);

   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   // Handshake: the MMU transfer happens on an edge where mmu_valid and mmu_ready
   // are both high; mmu_valid and the payload stay stable until then.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t              state_q;
   logic [ID_W-1:0]     rr_ptr_q;
   logic [ID_W-1:0]     grant_id_q;
   logic [CNT_W-1:0]    tmo_cnt_q;
   logic                busy_q;
   logic                mmu_valid_q;
   logic                mmu_write_q;
   logic [ADDR_W-1:0]   mmu_addr_q;
   logic [DATA_W-1:0]   mmu_wdata_q;
   logic [NUM_REQ-1:0]  req_done_q;
   logic                req_err_q;
   logic [DATA_W-1:0]   req_rdata_q;

   logic [ADDR_W-1:0]   addr_arr  [NUM_REQ];
   logic [DATA_W-1:0]   wdata_arr [NUM_REQ];

   logic                pick_vld_d;
   logic [ID_W-1:0]     pick_id_d;
   logic [ID_W-1:0]     rr_next_d;
   logic [NUM_REQ-1:0]  grant_onehot;
   logic                tmo_hit;
   int                  scan_idx;
   logic [ID_W-1:0]     scan_id;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
      assign wdata_arr[g] = req_wdata[g*DATA_W +: DATA_W];
   end

   // Scan from rr_ptr upward with wrap; iterating downward lets the closest hit win.
   always_comb begin
      pick_vld_d = 1'b0;
      pick_id_d  = '0;
      scan_idx   = 0;
      scan_id    = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         scan_idx = int'(rr_ptr_q) + k;
         if (scan_idx >= NUM_REQ) begin
            scan_idx = scan_idx - NUM_REQ;
         end
         scan_id = ID_W'(scan_idx);
         if (req_valid[scan_id]) begin
            pick_vld_d = 1'b1;
            pick_id_d  = scan_id;
         end
      end
   end

   assign rr_next_d    = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;
   assign grant_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id_q;
   assign tmo_hit      = (TIMEOUT != 0) && (tmo_cnt_q == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         rr_ptr_q    <= '0;
         grant_id_q  <= '0;
         tmo_cnt_q   <= '0;
         busy_q      <= 1'b0;
         mmu_valid_q <= 1'b0;
         mmu_write_q <= 1'b0;
         mmu_addr_q  <= '0;
         mmu_wdata_q <= '0;
         req_done_q  <= '0;
         req_err_q   <= 1'b0;
         req_rdata_q <= '0;
      end else begin
         req_done_q  <= '0;
         req_err_q   <= 1'b0;
         req_rdata_q <= '0;
         case (state_q)
            S_IDLE: begin
               if (pick_vld_d) begin
                  grant_id_q  <= pick_id_d;
                  mmu_write_q <= req_write[pick_id_d];
                  mmu_addr_q  <= addr_arr[pick_id_d];
                  mmu_wdata_q <= wdata_arr[pick_id_d];
                  mmu_valid_q <= 1'b1;
                  busy_q      <= 1'b1;
                  state_q     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (mmu_ready) begin
                  mmu_valid_q <= 1'b0;
                  tmo_cnt_q   <= '0;
                  state_q     <= S_WAIT;
               end
            end
            S_WAIT: begin
               // A completion arriving in the same cycle as the timeout still wins.
               if (mem_ready) begin
                  req_done_q  <= grant_onehot;
                  req_rdata_q <= mem_rdata;
                  state_q     <= S_DONE;
               end else if (tmo_hit) begin
                  req_done_q  <= grant_onehot;
                  req_err_q   <= 1'b1;
                  state_q     <= S_DONE;
               end else begin
                  tmo_cnt_q   <= tmo_cnt_q + 1'b1;
               end
            end
            S_DONE: begin
               rr_ptr_q <= rr_next_d;
               busy_q   <= 1'b0;
               state_q  <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign req_done  = req_done_q;
   assign req_err   = req_err_q;
   assign req_rdata = req_rdata_q;
   assign grant_id  = grant_id_q;
   assign busy      = busy_q;
   assign mmu_valid = mmu_valid_q;
   assign mmu_write = mmu_write_q;
   assign mmu_addr  = mmu_addr_q;
   assign mmu_wdata = mmu_wdata_q;
   assign dbg_state = state_q;

   a_done_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(req_done_q));
   a_valid_busy:  assert property (@(posedge clk) disable iff (reset) mmu_valid_q |-> busy_q);

endmodule

// File: tb/tb_vm_req_arbiter.sv
// Bench for vm_req_arbiter: directed vector table, fairness/wrap/reset sequences and
// randomized transactions checked against a round-robin reference model.
module tb_vm_req_arbiter;

   localparam int N   = 4;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int TMO = 8;

   logic              clk = 1'b0;
   logic              reset;
   logic [N-1:0]      req_valid;
   logic [N-1:0]      req_write;
   logic [N*AW-1:0]   req_addr;
   logic [N*DW-1:0]   req_wdata;
   logic [N-1:0]      req_done;
   logic              req_err;
   logic [DW-1:0]     req_rdata;
   logic [1:0]        grant_id;
   logic              busy;
   logic              mmu_valid;
   logic              mmu_write;
   logic [AW-1:0]     mmu_addr;
   logic [DW-1:0]     mmu_wdata;
   logic              mmu_ready;
   logic              mem_ready;
   logic [DW-1:0]     mem_rdata;
   logic [1:0]        dbg_state;

   always #5 clk = ~clk;

   vm_req_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_done(req_done), .req_err(req_err), .req_rdata(req_rdata),
      .grant_id(grant_id), .busy(busy),
      .mmu_valid(mmu_valid), .mmu_write(mmu_write), .mmu_addr(mmu_addr), .mmu_wdata(mmu_wdata),
      .mmu_ready(mmu_ready), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .dbg_state(dbg_state)
   );

   typedef struct {
      logic [N-1:0]  mask;
      logic [N-1:0]  wr;
      int            stall;
      int            mem_dly;
      logic          mem_iss;
      logic [DW-1:0] mrd;
      int            exp_id;
      logic          exp_err;
      logic [DW-1:0] exp_rd;
      int            exp_lat;
   } vec_t;

   int             n_checks = 0;
   int             n_errors = 0;
   logic [36:0]    exp_q[$];
   logic [AW-1:0]  tb_addr  [N];
   logic [DW-1:0]  tb_wdata [N];
   logic [N-1:0]   tb_write;
   vec_t           vt [10];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive_payload();
      for (int i = 0; i < N; i++) begin
         req_addr[i*AW +: AW]  = tb_addr[i];
         req_wdata[i*DW +: DW] = tb_wdata[i];
      end
      req_write = tb_write;
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      req_valid = '0;
      mmu_ready = 1'b0;
      mem_ready = 1'b0;
      repeat (2) step();
      reset = 1'b0;
   endtask

   // Runs one transaction from an IDLE cycle; mem_dly = WAIT cycles before mem_ready (<0: never).
   task automatic run_txn(input logic [N-1:0] mask, input int stall, input int mem_dly,
                          input bit mem_iss, input bit drop, input logic [DW-1:0] mrd,
                          input int exp_id, output logic [36:0] obs, output int lat,
                          output int vcnt);
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_wdata;
      logic          e_wr;
      bit            issue_ok;
      bit            got;
      int            w;
      e_addr   = tb_addr[exp_id];
      e_wdata  = tb_wdata[exp_id];
      e_wr     = tb_write[exp_id];
      drive_payload();
      req_valid = mask;
      mmu_ready = 1'b0;
      mem_ready = 1'b0;
      lat      = 0;
      vcnt     = 0;
      issue_ok = 1'b1;
      step();
      lat++;
      check("grant_id", 64'(grant_id), 64'(exp_id));
      for (int c = 0; c <= stall; c++) begin
         if (mmu_valid) vcnt++;
         if (!mmu_valid || !busy || mmu_addr !== e_addr || mmu_wdata !== e_wdata ||
             mmu_write !== e_wr) issue_ok = 1'b0;
         mmu_ready = (c == stall);
         mem_ready = mem_iss && (c < stall);
         mem_rdata = $urandom;
         if (c < stall) begin
            req_addr  = {$urandom, $urandom, $urandom, $urandom};
            req_wdata = {$urandom, $urandom, $urandom, $urandom};
            req_write = 4'($urandom);
         end
         step();
         lat++;
      end
      mmu_ready = 1'b0;
      mem_ready = 1'b0;
      check("issue_hold", 64'(issue_ok), 64'd1);
      if (drop) req_valid = '0;
      w   = 0;
      got = 1'b0;
      while (!got && w < 40) begin
         if (mmu_valid) vcnt++;
         mem_ready = (w == mem_dly);
         mem_rdata = (w == mem_dly) ? mrd : $urandom;
         step();
         lat++;
         w++;
         if (req_done != '0) got = 1'b1;
      end
      mem_ready = 1'b0;
      check("done_seen", 64'(got), 64'd1);
      obs = {req_done, req_err, req_rdata};
      req_valid = '0;
      step();
      check("quiet_after_done", 64'({req_done, req_err, req_rdata, busy, mmu_valid, dbg_state}), 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not reach the summary");
      $fatal(1);
   end

   initial begin
      logic [36:0]   obs;
      logic [36:0]   exp_word;
      int            lat;
      int            vcnt;
      int            order [5];
      int            n_seen;
      int            cyc;
      int            off_cnt;
      logic [N-1:0]  off_mask;
      logic [N-1:0]  mask;
      int            stall;
      int            dly;
      bit            iss;
      bit            drop;
      bit            tmo;
      logic [DW-1:0] mrd;
      int            exp_id;
      int            model_rr;

      for (int i = 0; i < N; i++) begin
         tb_addr[i]  = 32'h0000_1034 + 32'(i) * 32'h100;
         tb_wdata[i] = 32'hA5A5_0000 + 32'(i);
      end
      tb_write  = '0;
      mem_rdata = '0;
      drive_payload();

      //           mask     wr       st  dly mi    mrd            id err   exp_rd         lat
      vt[0] = '{4'b0100, 4'b0000, 0,  0, 1'b0, 32'hDEADBEEF, 2, 1'b0, 32'hDEADBEEF, 3};
      vt[1] = '{4'b1001, 4'b0000, 0,  0, 1'b0, 32'h11110003, 3, 1'b0, 32'h11110003, 3};
      vt[2] = '{4'b1001, 4'b0000, 0,  2, 1'b0, 32'h22220000, 0, 1'b0, 32'h22220000, 5};
      vt[3] = '{4'b0010, 4'b0010, 5,  0, 1'b0, 32'h0BAD0001, 1, 1'b0, 32'h0BAD0001, 8};
      vt[4] = '{4'b0001, 4'b0000, 0, -1, 1'b0, 32'h12345678, 0, 1'b1, 32'h00000000, 10};
      vt[5] = '{4'b0100, 4'b0000, 0,  7, 1'b0, 32'hCAFEF00D, 2, 1'b0, 32'hCAFEF00D, 10};
      vt[6] = '{4'b1000, 4'b1000, 2,  1, 1'b1, 32'h33330006, 3, 1'b0, 32'h33330006, 6};
      vt[7] = '{4'b0110, 4'b0000, 0,  0, 1'b0, 32'h44440007, 1, 1'b0, 32'h44440007, 3};
      vt[8] = '{4'b0110, 4'b0000, 1,  3, 1'b0, 32'h55550008, 2, 1'b0, 32'h55550008, 7};
      vt[9] = '{4'b0011, 4'b0000, 0,  0, 1'b0, 32'h66660009, 0, 1'b0, 32'h66660009, 3};

      // Reset state
      reset     = 1'b1;
      req_valid = '0;
      mmu_ready = 1'b0;
      mem_ready = 1'b0;
      repeat (3) step();
      check("reset_req_side", 64'({req_done, req_err, req_rdata, grant_id, busy}), 64'd0);
      check("reset_mmu_side", 64'({mmu_valid, mmu_write, mmu_addr, dbg_state}), 64'd0);
      check("reset_mmu_wdata", 64'(mmu_wdata), 64'd0);
      reset = 1'b0;

      // Directed vector table, rr_ptr starts at 0
      for (int v = 0; v < 10; v++) begin
         tb_write = vt[v].wr;
         run_txn(vt[v].mask, vt[v].stall, vt[v].mem_dly, vt[v].mem_iss, 1'b0, vt[v].mrd,
                 vt[v].exp_id, obs, lat, vcnt);
         exp_word = {4'(1 << vt[v].exp_id), vt[v].exp_err, vt[v].exp_rd};
         check($sformatf("vec%0d_done", v), 64'(obs), 64'(exp_word));
         check($sformatf("vec%0d_latency", v), 64'(lat), 64'(vt[v].exp_lat));
         check($sformatf("vec%0d_mmu_valid_cycles", v), 64'(vcnt), 64'(vt[v].stall + 1));
      end

      // Fairness: all four requesting, each drops for one cycle after its done
      do_reset();
      tb_write = '0;
      drive_payload();
      req_valid = 4'hF;
      mmu_ready = 1'b1;
      mem_ready = 1'b1;
      mem_rdata = 32'h0F0F_0F0F;
      n_seen   = 0;
      cyc      = 0;
      off_cnt  = 0;
      off_mask = '0;
      while (n_seen < 5 && cyc < 100) begin
         step();
         cyc++;
         if (req_done != '0) begin
            for (int i = 0; i < N; i++) if (req_done[i]) order[n_seen] = i;
            n_seen++;
            off_mask = req_done;
            off_cnt  = 2;
         end else if (off_cnt > 0) begin
            off_cnt--;
         end
         req_valid = (off_cnt > 0) ? (4'hF & ~off_mask) : 4'hF;
      end
      check("fair_grants_seen", 64'(n_seen), 64'd5);
      for (int i = 0; i < 5; i++) check($sformatf("fair_order%0d", i), 64'(order[i]), 64'(i % N));
      req_valid = '0;
      mmu_ready = 1'b0;
      mem_ready = 1'b0;
      repeat (2) step();

      // Reset in WAIT: first move rr_ptr to 3, then abort a grant to requester 3
      run_txn(4'b0100, 0, 0, 1'b0, 1'b0, 32'h77770002, 2, obs, lat, vcnt);
      check("pre_reset_done", 64'(obs), 64'({4'b0100, 1'b0, 32'h77770002}));
      tb_write = 4'b1000;
      drive_payload();
      req_valid = 4'b1000;
      step();
      check("pre_reset_grant", 64'(grant_id), 64'd3);
      mmu_ready = 1'b1;
      step();
      mmu_ready = 1'b0;
      step();
      check("pre_reset_in_wait", 64'({busy, mmu_valid, mmu_write}), 64'({1'b1, 1'b0, 1'b1}));
      reset     = 1'b1;
      req_valid = '0;
      step();
      check("midreset_req_side", 64'({req_done, req_err, req_rdata, grant_id, busy}), 64'd0);
      check("midreset_mmu_side", 64'({mmu_valid, mmu_write, mmu_addr, dbg_state}), 64'd0);
      reset = 1'b0;
      step();
      check("no_done_after_reset", 64'({req_done, busy}), 64'd0);
      tb_write = '0;
      run_txn(4'b1100, 0, 0, 1'b0, 1'b0, 32'h88880002, 2, obs, lat, vcnt);
      check("post_reset_grant", 64'(obs), 64'({4'b0100, 1'b0, 32'h88880002}));

      // Randomized transactions against the round-robin model
      do_reset();
      model_rr = 0;
      for (int t = 0; t < 40; t++) begin
         mask  = 4'($urandom_range(1, 15));
         stall = $urandom_range(0, 3);
         dly   = $urandom_range(0, 9);
         iss   = ($urandom_range(0, 1) == 1);
         drop  = ($urandom_range(0, 3) == 0);
         mrd   = $urandom;
         for (int i = 0; i < N; i++) begin
            tb_addr[i]  = $urandom;
            tb_wdata[i] = $urandom;
         end
         tb_write = 4'($urandom);
         exp_id = -1;
         for (int k = 0; k < N; k++) begin
            if (exp_id < 0 && mask[(model_rr + k) % N]) exp_id = (model_rr + k) % N;
         end
         tmo = (dly >= TMO);
         exp_q.push_back({4'(1 << exp_id), tmo, tmo ? 32'h0 : mrd});
         run_txn(mask, stall, dly, iss, drop, mrd, exp_id, obs, lat, vcnt);
         exp_word = exp_q.pop_front();
         check($sformatf("rand%0d_done", t), 64'(obs), 64'(exp_word));
         check($sformatf("rand%0d_latency", t), 64'(lat), 64'(3 + stall + (tmo ? TMO - 1 : dly)));
         check($sformatf("rand%0d_mmu_valid_cycles", t), 64'(vcnt), 64'(stall + 1));
         model_rr = (exp_id + 1) % N;
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/vm_req_arbiter.md
Name: vm_req_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the single MMU request port among NUM_REQ processor-side requesters in the virtual memory system.
- Grants one requester at a time and latches its operation (read/write, virtual address, write data).
- Drives the MMU handshake, waits for memory completion, then returns data and a one-cycle done pulse to the granted requester.
- A watchdog aborts any transaction whose completion never arrives, reporting an error instead of hanging the system.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 32, virtual address width.
- DATA_W, 32, data width.
- TIMEOUT, 1023, cycles allowed in WAIT before abort; 0 disables the watchdog.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester request pending.
- req_write  in  NUM_REQ  per-requester 1=write, 0=read.
- req_addr  in  NUM_REQ*ADDR_W  packed virtual addresses; requester i occupies slice [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  packed write data, same slicing.
- req_done  out  NUM_REQ  one-hot completion pulse.
- req_err  out  1  valid with req_done; 1 means the transaction timed out.
- req_rdata  out  DATA_W  return data, valid with req_done.
- grant_id  out  $clog2(NUM_REQ)  index of the current or last grant.
- busy  out  1  high in any state other than IDLE.
- mmu_valid  out  1  request to the MMU.
- mmu_write  out  1  latched write flag.
- mmu_addr  out  ADDR_W  latched address.
- mmu_wdata  out  DATA_W  latched write data.
- mmu_ready  in  1  MMU can accept a request.
- mem_ready  in  1  memory completion strobe.
- mem_rdata  in  DATA_W  memory return data.

Behaviour:
- Reset: state=IDLE, rr_ptr=0, grant_id=0, all outputs 0. Reset in any state aborts the transaction immediately; no done pulse is issued.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any req_valid is set, select the first set bit scanning from rr_ptr upward, with modulo NUM_REQ wrap.
  - At the clock edge, latch write, addr and wdata into the mmu_* registers, set grant_id, and go to ISSUE.
  - If no req_valid is set, stay in IDLE.
- ISSUE:
  - mmu_valid=1.
  - Transfer occurs on an edge where mmu_ready=1; then go to WAIT and reset the timeout counter to 0.
  - mmu_valid is held and the payload kept stable while mmu_ready=0; the stall time is unbounded and not counted by the watchdog.
- WAIT:
  - mmu_valid=0.
  - mem_ready is sampled only in this state; a mem_ready in ISSUE is ignored.
  - On mem_ready=1: capture mem_rdata into req_rdata, set req_err=0, go to DONE.
  - Otherwise increment the counter. When the counter reaches TIMEOUT (with TIMEOUT!=0): set req_rdata=0, req_err=1, go to DONE.
  - If mem_ready and timeout coincide, mem_ready wins (err=0).
- DONE (exactly one cycle):
  - req_done[grant_id]=1; req_rdata and req_err are valid.
  - rr_ptr <= (grant_id+1) mod NUM_REQ.
  - Next state is IDLE.
  - req_done, req_rdata and req_err return to 0 in all other cycles.
- Requester rules:
  - A requester holds req_valid until it sees req_done, and must deassert req_valid in the cycle after req_done.
  - The payload is latched at grant, so later changes to it are don't-care.
  - A requester dropping req_valid after grant does not cancel the transaction; its done pulse is still issued.
- Throughput:
  - Minimum 4 cycles per transaction (IDLE, ISSUE, WAIT, DONE) with mmu_ready=1 and mem_ready arriving in the first WAIT cycle.
  - Starvation-free: a waiting requester is served within NUM_REQ-1 other grants.
- busy is 0 only in IDLE.
- grant_id holds its value in IDLE.

Test Plan:
- Single read: req_valid=4'b0100, addr=0x0000_1234, mmu_ready=1, mem_ready one cycle into WAIT with rdata=0xDEADBEEF -> mmu_addr=0x1234 and mmu_write=0 during ISSUE; req_done=4'b0100, req_rdata=0xDEADBEEF, req_err=0 four cycles after request.
- Fairness: req_valid=4'b1111 held, each requester re-requesting after its done -> grant order 0,1,2,3,0; no requester skipped.
- Wrap-around: rr_ptr=3 (after a grant to 2), req_valid=4'b1001 -> grant 3 first, then 0.
- Write and MMU stall: requester 1 write, wdata=0xA5A5_0001, mmu_ready=0 for 5 cycles -> mmu_valid held 5+1 cycles with wdata stable; one transfer; done to requester 1 only.
- Timeout: TIMEOUT=8, mem_ready never asserted -> done pulse 8 cycles after entering WAIT with req_err=1 and req_rdata=0. Same case with mem_ready in the 8th cycle -> req_err=0.
- Reset mid-operation: assert reset during WAIT -> next cycle state IDLE, all outputs 0, no req_done; a subsequent request from requester 2 is granted first (rr_ptr=0 scan).
